fb_fade_ctrl: RTL and testbench
===============================

FB_FADE_CTRL -- requirements
Module: fb_fade_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- FB_WIDTH, 160, framebuffer width (pixels)
- FB_HEIGHT, 120, framebuffer height (pixels)
- FB_ADDRW, 15, write-address width, ≥ $clog2(FB_WIDTH*FB_HEIGHT)
- FB_DATAW, 4, colour-index width
- LFSR_LEN, 15, LFSR length; 2^LFSR_LEN-1 ≥ FB_WIDTH*FB_HEIGHT
- LFSR_TAPS, 15'b110000000000000, maximal-length tap mask
- FADE_WAIT, 600, frame pulses before fading; ≥ 1
- FADE_RATE, 3200, clk_pix cycles per fade write attempt; ≥ 2
REQ-002 Ports (name, direction, width, meaning); one clock, clk_pix; reset rst_n is asynchronous and active-low:
- clk_pix  in  1  pixel clock
- rst_n  in  1  async active-low reset
- start  in  1  begin fade sequence (pulse)
- abort  in  1  cancel sequence (pulse)
- frame  in  1  start-of-frame pulse from display timing
- fill_cidx  in  FB_DATAW  fade colour index, sampled on accepted start
- draw_req  in  1  drawing requester wants the write port
- draw_addr  in  FB_ADDRW  drawing write address
- draw_cidx  in  FB_DATAW  drawing colour index
- draw_ack  out  1  draw write accepted this cycle
- busy  out  1  sequence in progress
- done  out  1  sequence complete (1-cycle pulse)
- fb_we  out  1  framebuffer write enable
- fb_addr_write  out  FB_ADDRW  framebuffer write address
- fb_cidx_write  out  FB_DATAW  framebuffer write data

Function
REQ-003 FSM states: IDLE, WAIT, FADE, DONE; busy=1 in WAIT and FADE only.
REQ-004 IDLE: start=1 -> WAIT; latch fill_cidx; clear frame counter, rate counter and pending flag; LFSR=1.
REQ-005 start in any state other than IDLE: ignored.
REQ-006 WAIT: each frame pulse increments the frame counter; the FADE_WAIT-th pulse -> FADE. A frame pulse in the same cycle as the accepted start is not counted.
REQ-007 FADE: rate counter counts 0..FADE_RATE-1 while pending=0; at FADE_RATE-1 it wraps to 0 and sets pending. Rate counter frozen while pending=1.
REQ-008 Candidate address = LFSR-1 (width-truncated to FB_ADDRW); valid iff LFSR-1 < FB_WIDTH*FB_HEIGHT.
REQ-009 pending=1 with invalid candidate: advance LFSR one step; pending stays 1; no write.
REQ-010 pending=1 with valid candidate and draw_req=0: issue fade write {addr=LFSR-1, cidx=latched fill}; advance LFSR; clear pending.
REQ-011 pending=1 with valid candidate and draw_req=1: hold; LFSR unchanged.
REQ-012 LFSR is Fibonacci, shifts left; feedback = XOR-reduce(LFSR & LFSR_TAPS), which enters the LSB.
REQ-013 If an LFSR advance yields 1, the sequence is complete -> DONE. Every address 0..FB_WIDTH*FB_HEIGHT-1 is written exactly once per sequence.
REQ-014 DONE: done=1 for exactly one cycle; -> IDLE next cycle.
REQ-015 abort=1 in WAIT or FADE: -> IDLE next cycle; pending dropped; no done. abort has priority over start and frame.
REQ-016 Arbitration: draw_req always wins. draw_ack = draw_req, combinational, in every state.
REQ-017 The write port is registered: a draw or fade write decided in cycle N appears on fb_we/fb_addr_write/fb_cidx_write in cycle N+1, 1-cycle latency. fb_we=0 in cycles with no write.
REQ-018 Simultaneous draw_req and a due fade write: the draw is written; the fade write retries in the first cycle with draw_req=0.

Reset
REQ-019 While rst_n=0, asynchronously: state=IDLE, LFSR=1, all counters 0, pending=0, busy=0, done=0, fb_we=0, fb_addr_write=0, fb_cidx_write=0. draw_ack follows draw_req.
REQ-020 Reset asserted mid-sequence abandons it; no done pulse follows deassertion.

Verification
Bench parameters: FB_WIDTH=4, FB_HEIGHT=4, LFSR_LEN=5, LFSR_TAPS=5'b10100, FADE_WAIT=2, FADE_RATE=3, FB_ADDRW=5.
REQ-021 start with fill_cidx=4'hF, then 2 frame pulses, no draw_req -> exactly 16 writes (one per address 0..15, all cidx F), 31 LFSR steps, done pulses once, busy low afterwards.
REQ-022 frame pulse coincident with start, then 1 more frame pulse -> still in WAIT; 2nd counted pulse -> FADE.
REQ-023 draw_req held high for 10 cycles across a due fade write (addr 0x07, cidx 0x3) -> draw_ack high for all 10; fb_we carries draw writes 1 cycle later; fade write appears 1 cycle after draw_req drops; total fade writes remain 16.
REQ-024 abort during FADE after 5 fade writes -> IDLE next cycle, busy=0, no done, no further fade writes; new start restarts from LFSR=1.
REQ-025 start while busy -> ignored; fill colour and counters unchanged.
REQ-026 rst_n low mid-FADE -> all outputs 0 immediately (asynchronous); no done after release.

Source files
------------

// File: rtl/fb_fade_ctrl.sv
// -----------------------------------------------------------------------------
// fb_fade_ctrl
// Framebuffer fade-out controller. After a start pulse it waits FADE_WAIT frame
// pulses, then overwrites every framebuffer pixel exactly once with a latched
// fill colour. Pixels are visited in pseudo-random order driven by an LFSR, one
// write attempt every FADE_RATE pixel clocks. A drawing client shares the
// single framebuffer write port and always has priority over the fade.
//
// Ports
//   clk_pix        pixel clock
//   rst_n          asynchronous active-low reset
//   start          begin a fade sequence (pulse, accepted only when idle)
//   abort          cancel a running sequence (pulse)
//   frame          start-of-frame pulse from display timing
//   fill_cidx      fade colour index, sampled when start is accepted
//   draw_req       drawing client requests the write port
//   draw_addr      drawing client write address
//   draw_cidx      drawing client colour index
//   draw_ack       draw write accepted this cycle (equals draw_req)
//   busy           sequence in progress (waiting or fading)
//   done           one-cycle pulse when a sequence completes
//   fb_we          framebuffer write enable (registered)
//   fb_addr_write  framebuffer write address (registered)
//   fb_cidx_write  framebuffer write data (registered)
// -----------------------------------------------------------------------------
module fb_fade_ctrl #(
  parameter int                  FB_WIDTH  = 160,
  parameter int                  FB_HEIGHT = 120,
  parameter int                  FB_ADDRW  = 15,
  parameter int                  FB_DATAW  = 4,
  parameter int                  LFSR_LEN  = 15,
  parameter logic [LFSR_LEN-1:0] LFSR_TAPS = 15'b110000000000000,
  parameter int                  FADE_WAIT = 600,
  parameter int                  FADE_RATE = 3200
) (
  input  logic                clk_pix,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                frame,
  input  logic [FB_DATAW-1:0] fill_cidx,
  input  logic                draw_req,
  input  logic [FB_ADDRW-1:0] draw_addr,
  input  logic [FB_DATAW-1:0] draw_cidx,
  output logic                draw_ack,
  output logic                busy,
  output logic                done,
  output logic                fb_we,
  output logic [FB_ADDRW-1:0] fb_addr_write,
  output logic [FB_DATAW-1:0] fb_cidx_write
);

  localparam int PIXELS = FB_WIDTH * FB_HEIGHT;
  localparam int FCW    = $clog2(FADE_WAIT + 1);
  localparam int RCW    = $clog2(FADE_RATE);

  // PIXELS fits in LFSR_LEN+1 bits because 2^LFSR_LEN-1 >= PIXELS.
  localparam logic [LFSR_LEN:0]   PIXELS_L   = (LFSR_LEN + 1)'(PIXELS);
  localparam logic [LFSR_LEN-1:0] LFSR_SEED  = LFSR_LEN'(32'd1);
  localparam logic [FCW-1:0]      FRAME_LAST = FCW'(FADE_WAIT - 1);
  localparam logic [FCW-1:0]      FRAME_ONE  = FCW'(32'd1);
  localparam logic [RCW-1:0]      RATE_LAST  = RCW'(FADE_RATE - 1);
  localparam logic [RCW-1:0]      RATE_ONE   = RCW'(32'd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FADE = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                state_q,     state_d;
  logic [LFSR_LEN-1:0]   lfsr_q,      lfsr_d;
  logic [FCW-1:0]        frame_cnt_q, frame_cnt_d;
  logic [RCW-1:0]        rate_cnt_q,  rate_cnt_d;
  logic                  pending_q,   pending_d;
  logic [FB_DATAW-1:0]   fill_q,      fill_d;
  logic                  we_q,        we_d;
  logic [FB_ADDRW-1:0]   addr_q,      addr_d;
  logic [FB_DATAW-1:0]   cidx_q,      cidx_d;

  logic [LFSR_LEN-1:0]   lfsr_step;
  logic [LFSR_LEN-1:0]   cand_full;
  logic                  cand_valid;
  logic [FB_ADDRW-1:0]   cand_addr;

  // LFSR value 1 maps to pixel 0, so the all-ones..1 cycle covers 0..2^N-2.
  assign lfsr_step  = {lfsr_q[LFSR_LEN-2:0], ^(lfsr_q & LFSR_TAPS)};
  assign cand_full  = lfsr_q - LFSR_SEED;
  assign cand_valid = ({1'b0, cand_full} < PIXELS_L);
  assign cand_addr  = FB_ADDRW'(cand_full);

  assign draw_ack      = draw_req;
  assign busy          = (state_q == S_WAIT) || (state_q == S_FADE);
  assign done          = (state_q == S_DONE);
  assign fb_we         = we_q;
  assign fb_addr_write = addr_q;
  assign fb_cidx_write = cidx_q;

  // Next-state, counter, LFSR and write-port decision logic.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    frame_cnt_d = frame_cnt_q;
    rate_cnt_d  = rate_cnt_q;
    pending_d   = pending_q;
    fill_d      = fill_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    cidx_d      = cidx_q;

    // The drawing client owns the port whenever it asks for it.
    if (draw_req) begin
      we_d   = 1'b1;
      addr_d = draw_addr;
      cidx_d = draw_cidx;
    end else begin
      we_d   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WAIT;
          fill_d      = fill_cidx;
          frame_cnt_d = '0;
          rate_cnt_d  = '0;
          pending_d   = 1'b0;
          lfsr_d      = LFSR_SEED;
        end else begin
          state_d     = S_IDLE;
        end
      end

      S_WAIT: begin
        if (abort) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end else if (frame) begin
          frame_cnt_d = frame_cnt_q + FRAME_ONE;
          if (frame_cnt_q == FRAME_LAST) begin
            state_d = S_FADE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_FADE: begin
        if (abort) begin
          state_d   = S_IDLE;
          pending_d = 1'b0;
        end else if (!pending_q) begin
          // Pace write attempts; the counter freezes once an attempt is due.
          if (rate_cnt_q == RATE_LAST) begin
            rate_cnt_d = '0;
            pending_d  = 1'b1;
          end else begin
            rate_cnt_d = rate_cnt_q + RATE_ONE;
          end
        end else if (!cand_valid) begin
          // Off-screen LFSR values are skipped at one per cycle.
          lfsr_d = lfsr_step;
          if (lfsr_step == LFSR_SEED) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FADE;
          end
        end else if (!draw_req) begin
          we_d      = 1'b1;
          addr_d    = cand_addr;
          cidx_d    = fill_q;
          lfsr_d    = lfsr_step;
          pending_d = 1'b0;
          if (lfsr_step == LFSR_SEED) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FADE;
          end
        end else begin
          // Draw has the port; keep the fade write due for the next free cycle.
          state_d = S_FADE;
        end
      end

      S_DONE: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // State, counters, LFSR and registered write port.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      frame_cnt_q <= '0;
      rate_cnt_q  <= '0;
      pending_q   <= 1'b0;
      fill_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cidx_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      frame_cnt_q <= frame_cnt_d;
      rate_cnt_q  <= rate_cnt_d;
      pending_q   <= pending_d;
      fill_q      <= fill_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      cidx_q      <= cidx_d;
    end
  end

endmodule

// File: tb/tb_fb_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_fade_ctrl
// Self-checking bench for fb_fade_ctrl on a 4x4 framebuffer with a 5-bit LFSR.
// A reference model lists the expected fade addresses in visiting order and the
// cycle offset of each write from the counted frame pulse; a negedge monitor
// checks every write-port cycle against it and against the draw traffic.
// -----------------------------------------------------------------------------
module tb_fb_fade_ctrl;

  localparam int              W    = 4;
  localparam int              H    = 4;
  localparam int              AW   = 5;
  localparam int              DW   = 4;
  localparam int              LL   = 5;
  localparam logic [LL-1:0]   TAPS = 5'b10100;
  localparam int              FW   = 2;
  localparam int              FR   = 3;
  localparam int              NPIX = W * H;

  logic          clk_pix   = 1'b0;
  logic          rst_n     = 1'b0;
  logic          start     = 1'b0;
  logic          abort     = 1'b0;
  logic          frame     = 1'b0;
  logic [DW-1:0] fill_cidx = '0;
  logic          draw_req  = 1'b0;
  logic [AW-1:0] draw_addr = '0;
  logic [DW-1:0] draw_cidx = '0;
  logic          draw_ack;
  logic          busy;
  logic          done;
  logic          fb_we;
  logic [AW-1:0] fb_addr_write;
  logic [DW-1:0] fb_cidx_write;

  fb_fade_ctrl #(
    .FB_WIDTH (W),  .FB_HEIGHT(H),  .FB_ADDRW (AW), .FB_DATAW(DW),
    .LFSR_LEN (LL), .LFSR_TAPS(TAPS), .FADE_WAIT(FW), .FADE_RATE(FR)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .start(start), .abort(abort),
    .frame(frame), .fill_cidx(fill_cidx), .draw_req(draw_req),
    .draw_addr(draw_addr), .draw_cidx(draw_cidx), .draw_ack(draw_ack),
    .busy(busy), .done(done), .fb_we(fb_we), .fb_addr_write(fb_addr_write),
    .fb_cidx_write(fb_cidx_write)
  );

  always #5 clk_pix = ~clk_pix;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic          pd_req = 1'b0;
  logic [AW-1:0] pd_addr = '0;
  logic [DW-1:0] pd_cidx = '0;
  int            fade_idx = 0;
  logic [NPIX-1:0] fade_mask = '0;
  int            fade_time = 0;
  int            done_cnt = 0;
  int            done_time = 0;
  logic [DW-1:0] exp_fill = '0;
  bit            check_timing = 1'b0;
  int            e0 = 0;
  int            exp_addr[$];
  int            exp_off[$];
  int            model_total = 0;

  // Walk the maximal-length sequence from 1 back to 1. On-screen values cost a
  // full pacing period plus the write cycle, off-screen values one skip cycle.
  function automatic void build_model();
    int s, off, fb;
    s = 1; off = 0;
    do begin
      if (s - 1 < NPIX) begin
        off += FR + 1;
        exp_addr.push_back(s - 1);
        exp_off.push_back(off);
      end else begin
        off += 1;
      end
      fb = $countones(s & int'(TAPS)) % 2;
      s  = ((s << 1) | fb) % (1 << LL);
    end while (s != 1);
    model_total = off;
  endfunction

  // Cycle counter and capture of the draw request seen at each active edge.
  initial forever begin
    @(posedge clk_pix);
    cyc++;
    pd_req  = rst_n ? draw_req : 1'b0;
    pd_addr = draw_addr;
    pd_cidx = draw_cidx;
  end

  // Write-port scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk_pix);
    if (rst_n) begin
      checks++;
      if (draw_ack !== draw_req) begin
        errors++;
        $display("FAIL draw_ack: got %b want %b (cyc %0d)", draw_ack, draw_req, cyc);
      end
      if (pd_req) begin
        checks++;
        if (fb_we !== 1'b1 || fb_addr_write !== pd_addr || fb_cidx_write !== pd_cidx) begin
          errors++;
          $display("FAIL draw_write: got we=%b a=%h c=%h want we=1 a=%h c=%h (cyc %0d)",
                   fb_we, fb_addr_write, fb_cidx_write, pd_addr, pd_cidx, cyc);
        end
      end else if (fb_we === 1'b1) begin
        checks++;
        if (fade_idx >= exp_addr.size()) begin
          errors++;
          $display("FAIL fade_extra: got write a=%h beyond %0d expected writes (cyc %0d)",
                   fb_addr_write, exp_addr.size(), cyc);
        end else begin
          if (fb_addr_write !== AW'(exp_addr[fade_idx]) || fb_cidx_write !== exp_fill) begin
            errors++;
            $display("FAIL fade_write[%0d]: got a=%h c=%h want a=%h c=%h", fade_idx,
                     fb_addr_write, fb_cidx_write, AW'(exp_addr[fade_idx]), exp_fill);
          end
          if (check_timing) begin
            checks++;
            if (cyc != e0 + exp_off[fade_idx]) begin
              errors++;
              $display("FAIL fade_time[%0d]: got cyc %0d want %0d", fade_idx, cyc,
                       e0 + exp_off[fade_idx]);
            end
          end
        end
        if (fb_addr_write < AW'(NPIX)) begin
          checks++;
          if (fade_mask[fb_addr_write[3:0]]) begin
            errors++;
            $display("FAIL fade_dup: got second write to %h want single", fb_addr_write);
          end
          fade_mask[fb_addr_write[3:0]] = 1'b1;
        end
        fade_time = cyc;
        fade_idx++;
      end else begin
        checks++;
        if (fb_we !== 1'b0) begin
          errors++;
          $display("FAIL fb_we_idle: got %b want 0 (cyc %0d)", fb_we, cyc);
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_time = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_at_done: got %b want 0", busy);
        end
      end
    end
  end

  // Hard stop so a stuck run still ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_pix);
      #2;
    end
  endtask

  task automatic begin_seq(input logic [DW-1:0] fill, input bit with_frame);
    fade_idx  = 0;
    fade_mask = '0;
    done_cnt  = 0;
    exp_fill  = fill;
    start     = 1'b1;
    fill_cidx = fill;
    frame     = with_frame;
    tick(1);
    start     = 1'b0;
    frame     = 1'b0;
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    e0    = cyc + 1;
    tick(1);
    frame = 1'b0;
  endtask

  task automatic wait_fades(input int n, input int budget, output bit to);
    int k = 0;
    while (fade_idx < n && k < budget) begin
      tick(1);
      k++;
    end
    to = (fade_idx < n);
  endtask

  task automatic wait_done(input int budget, output bit to);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      tick(1);
      k++;
    end
    to = (done_cnt == 0);
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fb_we !== 1'b0 || fb_addr_write !== '0 || fb_cidx_write !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b a=%h c=%h want all 0",
               busy, done, fb_we, fb_addr_write, fb_cidx_write);
    end
    draw_req = 1'b1;
    #1;
    checks++;
    if (draw_ack !== 1'b1) begin
      errors++;
      $display("FAIL reset_ack_hi: got %b want 1", draw_ack);
    end
    draw_req = 1'b0;
    #1;
    checks++;
    if (draw_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack_lo: got %b want 0", draw_ack);
    end
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_full_fade();
    bit to;
    check_timing = 1'b0;
    begin_seq(4'hF, 1'b0);
    tick(2);
    pulse_frame();
    tick(3);
    checks++;
    if (busy !== 1'b1 || fade_idx != 0) begin
      errors++;
      $display("FAIL full_wait: got busy=%b writes=%0d want busy=1 writes=0", busy, fade_idx);
    end
    check_timing = 1'b1;
    pulse_frame();
    wait_done(400, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL full_done_timeout: got no done want done");
    end
    checks++;
    if (fade_idx != NPIX || fade_mask !== '1) begin
      errors++;
      $display("FAIL full_coverage: got writes=%0d mask=%h want %0d/ffff", fade_idx, fade_mask, NPIX);
    end
    checks++;
    if (done_time != e0 + model_total) begin
      errors++;
      $display("FAIL full_done_time: got cyc %0d want %0d", done_time, e0 + model_total);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_after: got busy=%b done=%b want 0 0", busy, done);
    end
    tick(5);
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL full_done_once: got %0d want 1", done_cnt);
    end
    check_timing = 1'b0;
  endtask

  task automatic test_frame_coincident();
    bit to;
    logic [DW-1:0] a;
    a = DW'($urandom_range(0, 15));
    check_timing = 1'b0;
    begin_seq(a, 1'b1);
    tick(1);
    pulse_frame();
    tick(10);
    checks++;
    if (busy !== 1'b1 || fade_idx != 0) begin
      errors++;
      $display("FAIL coinc_still_wait: got busy=%b writes=%0d want 1/0", busy, fade_idx);
    end
    start = 1'b1; fill_cidx = ~a;
    tick(1);
    start = 1'b0;
    tick(3);
    checks++;
    if (busy !== 1'b1 || fade_idx != 0) begin
      errors++;
      $display("FAIL busy_start_wait: got busy=%b writes=%0d want 1/0", busy, fade_idx);
    end
    check_timing = 1'b1;
    pulse_frame();
    wait_fades(4, 100, to);
    start = 1'b1; fill_cidx = ~a;
    tick(1);
    start = 1'b0;
    wait_done(400, to);
    checks++;
    if (to || fade_idx != NPIX || done_cnt != 1) begin
      errors++;
      $display("FAIL coinc_result: got to=%b writes=%0d done=%0d want 0/%0d/1", to, fade_idx, done_cnt, NPIX);
    end
    checks++;
    if (done_time != e0 + model_total) begin
      errors++;
      $display("FAIL coinc_done_time: got cyc %0d want %0d", done_time, e0 + model_total);
    end
    check_timing = 1'b0;
    tick(2);
  endtask

  task automatic test_draw_arbitration();
    bit to;
    int c0, w, want, k;
    check_timing = 1'b1;
    begin_seq(DW'($urandom_range(0, 15)), 1'b0);
    pulse_frame();
    pulse_frame();
    wait_fades(2, 100, to);
    check_timing = 1'b0;
    w  = fade_time;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      draw_req = 1'b1; draw_addr = 5'h07; draw_cidx = 4'h3;
      tick(1);
      checks++;
      if (draw_ack !== 1'b1) begin
        errors++;
        $display("FAIL burst_ack[%0d]: got %b want 1", i, draw_ack);
      end
    end
    draw_req = 1'b0;
    want = c0 + 11;
    if (w + exp_off[2] - exp_off[1] > want) want = w + exp_off[2] - exp_off[1];
    wait_fades(3, 40, to);
    checks++;
    if (to || fade_time != want) begin
      errors++;
      $display("FAIL burst_retry: got to=%b cyc %0d want cyc %0d", to, fade_time, want);
    end
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      draw_req  = ($urandom_range(0, 2) == 0);
      draw_addr = AW'($urandom_range(0, 31));
      draw_cidx = DW'($urandom_range(0, 15));
      tick(1);
      k++;
    end
    draw_req = 1'b0;
    checks++;
    if (done_cnt != 1 || fade_idx != NPIX || fade_mask !== '1) begin
      errors++;
      $display("FAIL draw_mix_result: got done=%0d writes=%0d mask=%h want 1/%0d/ffff",
               done_cnt, fade_idx, fade_mask, NPIX);
    end
    tick(2);
  endtask

  task automatic test_abort();
    bit to;
    check_timing = 1'b0;
    begin_seq(DW'($urandom_range(0, 15)), 1'b0);
    pulse_frame();
    abort = 1'b1; frame = 1'b1; start = 1'b1;
    tick(1);
    abort = 1'b0; frame = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_wait: got busy=%b want 0", busy);
    end
    tick(10);
    checks++;
    if (busy !== 1'b0 || fade_idx != 0) begin
      errors++;
      $display("FAIL abort_wait_idle: got busy=%b writes=%0d want 0/0", busy, fade_idx);
    end
    begin_seq(DW'($urandom_range(0, 15)), 1'b0);
    pulse_frame();
    pulse_frame();
    wait_fades(5, 200, to);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    checks++;
    if (to || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_fade: got to=%b busy=%b want 0/0", to, busy);
    end
    tick(30);
    checks++;
    if (fade_idx != 5 || done_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: got writes=%0d done=%0d busy=%b want 5/0/0", fade_idx, done_cnt, busy);
    end
    check_timing = 1'b1;
    begin_seq(DW'($urandom_range(0, 15)), 1'b0);
    pulse_frame();
    pulse_frame();
    wait_done(400, to);
    checks++;
    if (to || fade_idx != NPIX || done_time != e0 + model_total) begin
      errors++;
      $display("FAIL abort_restart: got to=%b writes=%0d done cyc %0d want 0/%0d/%0d",
               to, fade_idx, done_time, NPIX, e0 + model_total);
    end
    check_timing = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    bit to;
    check_timing = 1'b0;
    begin_seq(DW'($urandom_range(0, 15)), 1'b0);
    pulse_frame();
    pulse_frame();
    wait_fades(3, 200, to);
    draw_req = 1'b1; draw_addr = 5'h09; draw_cidx = 4'h6;
    tick(1);
    checks++;
    if (to || fb_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got to=%b we=%b busy=%b want 0/1/1", to, fb_we, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || fb_we !== 1'b0 || fb_addr_write !== '0 ||
        fb_cidx_write !== '0 || draw_ack !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b we=%b a=%h c=%h ack=%b want 0/0/0/0/0/1",
               busy, done, fb_we, fb_addr_write, fb_cidx_write, draw_ack);
    end
    draw_req = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(150);
    checks++;
    if (done_cnt != 0 || fade_idx != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got done=%0d writes=%0d busy=%b want 0/3/0", done_cnt, fade_idx, busy);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_full_fade();
    test_frame_coincident();
    test_draw_arbitration();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
